// File: rtl/hamming_decoder_12_8.sv
// Bit-serial Hamming(12,8) SEC decoder: scans one codeword position per clock
// to build the syndrome, fixes a single-bit error and hands the data byte downstream.
module hamming_decoder_12_8 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      codeword_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       data_out,
  output logic [3:0]       syndrome,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FIX,
    OUT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [11:0] cw_reg;
  logic [3:0]  syn;
  logic [3:0]  pos;
  logic [3:0]  pos_idx;
  logic [7:0]  raw_data;
  logic [7:0]  data_flip;
  logic [7:0]  fix_data;
  logic        corr_hit;
  logic        uncorr_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (pos == 4'd12) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pos_idx  = pos - 4'd1;
  assign raw_data = {cw_reg[11], cw_reg[10], cw_reg[9], cw_reg[8],
                     cw_reg[6],  cw_reg[5],  cw_reg[4], cw_reg[2]};

  // A syndrome naming a parity position still counts as corrected, but only
  // syndromes that land on a data position change the delivered byte.
  always_comb begin
    data_flip  = 8'h00;
    corr_hit   = 1'b0;
    uncorr_hit = 1'b0;
    if (syn >= 4'd13) begin
      uncorr_hit = 1'b1;
    end else if (syn != 4'd0) begin
      corr_hit = 1'b1;
      case (syn)
        4'd3:    data_flip = 8'h01;
        4'd5:    data_flip = 8'h02;
        4'd6:    data_flip = 8'h04;
        4'd7:    data_flip = 8'h08;
        4'd9:    data_flip = 8'h10;
        4'd10:   data_flip = 8'h20;
        4'd11:   data_flip = 8'h40;
        4'd12:   data_flip = 8'h80;
        default: data_flip = 8'h00;
      endcase
    end
  end

  assign fix_data = raw_data ^ data_flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_reg <= 12'h000;
      syn    <= 4'd0;
      pos    <= 4'd0;
    end else if (accept) begin
      cw_reg <= codeword_in;
      syn    <= 4'd0;
      pos    <= 4'd1;
    end else if (state == SCAN) begin
      if (cw_reg[pos_idx]) begin
        syn <= syn ^ pos;
      end
      pos <= pos + 4'd1;
    end
  end

  // Results are captured only in FIX so they stay put through OUT and beyond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out          <= 8'h00;
      syndrome          <= 4'd0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
      corr_count        <= '0;
      uncorr_count      <= '0;
    end else if (state == FIX) begin
      data_out          <= fix_data;
      syndrome          <= syn;
      err_corrected     <= corr_hit;
      err_uncorrectable <= uncorr_hit;
      if (corr_hit && (corr_count != CNT_MAX)) begin
        corr_count <= corr_count + CNT_ONE;
      end
      if (uncorr_hit && (uncorr_count != CNT_MAX)) begin
        uncorr_count <= uncorr_count + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/hamming_decoder_12_8.md
# hamming_decoder_12_8

Bit-serial Hamming(12,8) single-error-correcting decoder. It is the consumer of the 12-bit codewords produced by the team's Hamming encoder stage. Each accepted codeword is scanned one position per clock to build a 4-bit syndrome. The block then corrects any single-bit error, extracts the 8 data bits, and presents them with error flags on a valid/ready output port. Saturating counters track corrected and uncorrectable words.

## Interface
- CNT_W, 16, width of the corrected and uncorrectable error counters
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  codeword_in is valid
- in_ready  out  1  block can accept a codeword
- codeword_in  in  12  codeword; position p (1..12) is bit p-1; parity bits at positions 1, 2, 4, 8
- out_valid  out  1  data_out and the flags are valid
- out_ready  in  1  downstream accepts the output
- data_out  out  8  decoded data, d0..d7 taken from positions 3, 5, 6, 7, 9, 10, 11, 12
- syndrome  out  4  final syndrome of the current word
- err_corrected  out  1  syndrome was 1..12 and that bit was flipped
- err_uncorrectable  out  1  syndrome was 13..15
- corr_count  out  CNT_W  count of words with err_corrected, saturating
- uncorr_count  out  CNT_W  count of words with err_uncorrectable, saturating

## Operation
- Parity is even. Parity bit 2^j covers every position with bit j set.
- Syndrome = XOR of the position indices p whose codeword bit is 1.
- FSM states are IDLE, SCAN, FIX and OUT.
- IDLE:
  - in_ready = 1; in_ready is 0 in every other state.
  - On in_valid & in_ready: latch codeword_in, clear syn, set pos = 1, go to SCAN.
- SCAN:
  - Each cycle: if cw_reg[pos-1] = 1 then syn ^= pos; then pos++.
  - After position 12 is processed, go to FIX. SCAN lasts exactly 12 cycles.
- FIX (one cycle):
  - syn = 0: no error.
  - syn 1..12: flip cw bit syn-1, assert err_corrected.
  - syn 13..15: leave the word uncorrected, assert err_uncorrectable; data_out is the raw data bits.
  - Register data_out, syndrome and the flags; increment the matching counter (saturating); go to OUT.
- OUT:
  - out_valid = 1; data_out, syndrome and the flags are held stable.
  - On out_ready: go to IDLE.
- A double error whose syndrome lands in 1..12 is miscorrected. This is a known limitation; there is no SECDED.
- Counters saturate at 2^CNT_W-1 and are never cleared except by rst.
- in_valid while not in IDLE is ignored. The upstream stage must hold codeword_in until in_ready is seen.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-SCAN or mid-OUT):
  - state = IDLE, in_ready = 1, out_valid = 0.
  - data_out, syndrome, both flags and both counters = 0; cw_reg, syn and pos are cleared.
  - Any word in flight is discarded.
- Accept edge is E0. SCAN runs on E1..E12, FIX on E13, and out_valid is high from E13.
- Latency from the accept edge to out_valid is 13 cycles.
- If out_ready is high at E14, the handshake completes at E14, in_ready is 1 after E14, and the next accept is at E15.
- Best-case throughput is one word per 15 cycles.
- out_ready held low: the block holds OUT indefinitely with its outputs unchanged and in_ready = 0.
- out_ready high before out_valid has no effect.
- Flags and syndrome are valid only while out_valid = 1. They retain their last values after leaving OUT until the next FIX.

## Test plan
- Clean word: codeword_in = 0xA27 -> data_out = 0xA5, syndrome = 0, no flags, both counters unchanged, out_valid 13 cycles after accept.
- Data-bit error: 0xA07 (position 6 flipped) -> syndrome = 6, err_corrected = 1, data_out = 0xA5, corr_count = 1.
- Parity-bit error: 0xAA7 (position 8 flipped) -> syndrome = 8, err_corrected = 1, data_out = 0xA5, corr_count increments.
- Uncorrectable: 0x226 (positions 1 and 12 flipped) -> syndrome = 13, err_uncorrectable = 1, data_out = 0x25, uncorr_count = 1.
- Backpressure and reset:
  - out_ready held low for 20 cycles -> outputs stable, in_ready = 0, a second in_valid is ignored.
  - rst pulsed during SCAN -> out_valid = 0, in_ready = 1, counters = 0; the next word 0x000 decodes to 0x00 with no flags.
- Saturation: CNT_W = 2, seven consecutive single-error words -> corr_count stops at 3.
